// File: rtl/cmd_decode_pkg.sv
// Shared definitions for the host command decoder: header layout, memory-request
// packing and the decoder state encoding.
package cmd_decode_pkg;

    // Header byte 0 layout and overall header length
    localparam logic [3:0]  CMD_SYNC_DEFAULT = 4'h5;
    localparam int unsigned CMD_B0_WR_BIT    = 0;
    localparam int unsigned CMD_B0_AINCR_BIT = 1;
    localparam int unsigned CMD_B0_WSIZE_LSB = 2;
    localparam int unsigned CMD_HDR_LEN      = 6;

    // Memory request word: {wr, aincr, wsize[1:0], wcount[7:0], addr[31:0]}
    localparam int unsigned MREQ_NBIT = 44;

    localparam logic [1:0] MREQ_WSIZE_VAL_1BYTE   = 2'd0;
    localparam logic [1:0] MREQ_WSIZE_VAL_2BYTE   = 2'd1;
    localparam logic [1:0] MREQ_WSIZE_VAL_4BYTE   = 2'd2;
    localparam logic [1:0] MREQ_WSIZE_VAL_INVALID = 2'd3;

    typedef enum logic [1:0] {
        StHdr0,
        StHdr1,
        StAddr,
        StIssue
    } state_t;

    function automatic logic [MREQ_NBIT-1:0] pack_mreq(
        input logic        wr,
        input logic        aincr,
        input logic [1:0]  wsize,
        input logic [7:0]  wcount,
        input logic [31:0] addr
    );
        return {wr, aincr, wsize, wcount, addr};
    endfunction

endpackage

// File: rtl/cmd_decode_if.sv
// Host rx stream, memory-request handshake and payload stream of the command
// decoder. Signal prefixes are relative to the decoder (master side).
interface cmd_decode_if;
    import cmd_decode_pkg::*;

    logic [7:0]           i_rx_data;
    logic                 i_rx_valid;
    logic                 o_rx_ready;

    logic                 o_mreq_valid;
    logic                 i_mreq_ready;
    logic [MREQ_NBIT-1:0] o_mreq;

    logic [7:0]           o_pl_data;
    logic                 o_pl_valid;
    logic                 i_pl_ready;

    logic                 o_err;

    // Decoder side
    modport master (
        input  i_rx_data, i_rx_valid, i_mreq_ready, i_pl_ready,
        output o_rx_ready, o_mreq_valid, o_mreq, o_pl_data, o_pl_valid, o_err
    );

    // Host / cmd_wb side
    modport slave (
        output i_rx_data, i_rx_valid, i_mreq_ready, i_pl_ready,
        input  o_rx_ready, o_mreq_valid, o_mreq, o_pl_data, o_pl_valid, o_err
    );

endinterface

// File: rtl/cmd_decode.sv
// Byte-stream command decoder: parses a 6-byte header into a memory request,
// forwards write payload to cmd_wb and stalls the host stream on reads until
// the request is acknowledged.
module cmd_decode
    import cmd_decode_pkg::*;
#(
    parameter logic [3:0]  CMD_SYNC    = CMD_SYNC_DEFAULT,
    parameter int unsigned HDR_TIMEOUT = 1000
) (
    input logic             i_clk,
    input logic             i_rst,
    cmd_decode_if.master    bus
);

    localparam int unsigned      CNT_W   = $clog2(HDR_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HDR_TIMEOUT);

    state_t               state_q;
    logic                 live_q;
    logic                 wr_q;
    logic                 aincr_q;
    logic [1:0]           wsize_q;
    logic [7:0]           wcount_q;
    logic [23:0]          addr_lo_q;
    logic [1:0]           addr_idx_q;
    logic [CNT_W-1:0]     idle_cnt_q;
    logic                 mreq_valid_q;
    logic [MREQ_NBIT-1:0] mreq_q;
    logic                 err_q;

    logic                 rx_ready;
    logic                 rx_accept;
    logic                 pl_valid;
    logic [3:0]           b0_sync;
    logic [1:0]           b0_wsize;
    logic                 b0_bad;

    // Decode header byte 0 fields straight off the rx bus
    always_comb begin
        b0_sync  = bus.i_rx_data[7:4];
        b0_wsize = bus.i_rx_data[CMD_B0_WSIZE_LSB +: 2];
        b0_bad   = (b0_sync != CMD_SYNC) || (b0_wsize == MREQ_WSIZE_VAL_INVALID);
    end

    // Host ready and payload passthrough per state
    always_comb begin
        rx_ready = 1'b0;
        pl_valid = 1'b0;
        unique case (state_q)
            StHdr0, StHdr1, StAddr: rx_ready = live_q;
            StIssue: begin
                // Reads hold the host stream; writes hand it straight to cmd_wb
                if (wr_q) begin
                    rx_ready = bus.i_pl_ready;
                    pl_valid = bus.i_rx_valid;
                end
            end
            default: ;
        endcase
        rx_accept = rx_ready && bus.i_rx_valid;
    end

    // Header parser, request issue and inter-byte timeout
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= StHdr0;
            live_q       <= 1'b0;
            wr_q         <= 1'b0;
            aincr_q      <= 1'b0;
            wsize_q      <= 2'd0;
            wcount_q     <= 8'd0;
            addr_lo_q    <= 24'd0;
            addr_idx_q   <= 2'd0;
            idle_cnt_q   <= '0;
            mreq_valid_q <= 1'b0;
            mreq_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            // live_q keeps the host stream stalled until the first edge out of reset
            live_q <= 1'b1;
            err_q  <= 1'b0;
            case (state_q)
                StHdr0: begin
                    idle_cnt_q <= '0;
                    if (rx_accept) begin
                        if (b0_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            wr_q       <= bus.i_rx_data[CMD_B0_WR_BIT];
                            aincr_q    <= bus.i_rx_data[CMD_B0_AINCR_BIT];
                            wsize_q    <= b0_wsize;
                            addr_idx_q <= 2'd0;
                            state_q    <= StHdr1;
                        end
                    end
                end
                StHdr1, StAddr: begin
                    if (rx_accept) begin
                        idle_cnt_q <= '0;
                        if (state_q == StHdr1) begin
                            wcount_q <= bus.i_rx_data;
                            state_q  <= StAddr;
                        end else if (addr_idx_q == 2'd3) begin
                            mreq_q       <= pack_mreq(wr_q, aincr_q, wsize_q, wcount_q,
                                                      {bus.i_rx_data, addr_lo_q});
                            mreq_valid_q <= 1'b1;
                            state_q      <= StIssue;
                        end else begin
                            // Little-endian: shift in from the top, lowest byte ends at [7:0]
                            addr_lo_q  <= {bus.i_rx_data, addr_lo_q[23:8]};
                            addr_idx_q <= addr_idx_q + 2'd1;
                        end
                    end else if (idle_cnt_q == CNT_MAX) begin
                        // A byte on this same edge would have taken the branch above
                        idle_cnt_q <= '0;
                        err_q      <= 1'b1;
                        state_q    <= StHdr0;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + CNT_W'(1);
                    end
                end
                StIssue: begin
                    idle_cnt_q <= '0;
                    if (mreq_valid_q && bus.i_mreq_ready) begin
                        mreq_valid_q <= 1'b0;
                        state_q      <= StHdr0;
                    end
                end
                default: state_q <= StHdr0;
            endcase
        end
    end

    assign bus.o_rx_ready   = rx_ready;
    assign bus.o_pl_data    = bus.i_rx_data;
    assign bus.o_pl_valid   = pl_valid;
    assign bus.o_mreq_valid = mreq_valid_q;
    assign bus.o_mreq       = mreq_q;
    assign bus.o_err        = err_q;

endmodule
